// File: rtl/riscv_mc_sequencer_if.sv
// Memory-side handshake bundle for the multi-cycle sequencer:
// instruction fetch port and data access port.
interface riscv_mc_sequencer_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_rvalid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata,
    output dmem_req,
    output dmem_we,
    input  dmem_rvalid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata,
    input  dmem_req,
    input  dmem_we,
    output dmem_rvalid
  );
endinterface

// File: rtl/riscv_mc_sequencer.sv
// Multi-cycle RV32I sequencer: owns PC, IR and retire count,
// steps IFETCH/EXEC/MEM/WB over variable-latency memories.
module riscv_mc_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32,
  parameter int              TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_mc_sequencer_if.master mem,
  output logic [31:0]          instruction,
  input  logic                 dec_load,
  input  logic                 dec_store,
  input  logic                 dec_reg_wr,
  input  logic                 dec_illegal,
  input  logic [XLEN-1:0]      next_pc,
  output logic [XLEN-1:0]      pc,
  output logic                 reg_wr_en,
  output logic [CNT_W-1:0]     instret,
  output logic                 halted,
  output logic [1:0]           halt_cause
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  // wait_q counts ack-less cycles; the TIMEOUT-th one halts
  localparam int WAIT_W =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_ILL   = 2'd1;
  localparam logic [1:0] C_TMO   = 2'd2;
  localparam logic [1:0] C_ALIGN = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IFETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic [XLEN-1:0]   pc_d;
  logic [31:0]       ir_d;
  logic [CNT_W-1:0]  instret_d;
  logic [1:0]        cause_d;
  logic              waiting;
  logic              pc_ok;
  logic              is_mem;

  assign pc_ok  = (next_pc[1:0] == 2'b00);
  assign is_mem = dec_load | dec_store;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    pc_d      = pc;
    ir_d      = instruction;
    instret_d = instret;
    cause_d   = halt_cause;
    waiting   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_IFETCH;
        wait_d  = '0;
      end
      S_IFETCH: begin
        if (mem.imem_rvalid) begin
          ir_d    = mem.imem_rdata;
          state_d = S_EXEC;
        end else begin
          waiting = 1'b1;
        end
      end
      S_EXEC: begin
        unique case (1'b1)
          dec_illegal: begin
            state_d = S_HALT;
            cause_d = C_ILL;
          end
          is_mem: begin
            state_d = S_MEM;
            wait_d  = '0;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem.dmem_rvalid) begin
          state_d = S_WB;
        end else begin
          waiting = 1'b1;
        end
      end
      S_WB: begin
        if (!pc_ok) begin
          state_d = S_HALT;
          cause_d = C_ALIGN;
        end else begin
          pc_d      = next_pc;
          instret_d = instret + CNT_W'(1);
          state_d   = S_IFETCH;
          wait_d    = '0;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // an ack always wins, so this only runs on ack-less cycles
    if (waiting && TIMEOUT != 0) begin
      if (wait_q == WAIT_LAST) begin
        state_d = S_HALT;
        cause_d = C_TMO;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      pc          <= RESET_PC;
      instruction <= NOP;
      instret     <= '0;
      halt_cause  <= C_NONE;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      pc          <= pc_d;
      instruction <= ir_d;
      instret     <= instret_d;
      halt_cause  <= cause_d;
    end
  end

  assign mem.imem_req  = (state_q == S_IFETCH);
  assign mem.imem_addr = pc;
  assign mem.dmem_req  = (state_q == S_MEM);
  assign mem.dmem_we   = (state_q == S_MEM) & dec_store;
  assign halted        = (state_q == S_HALT);
  assign reg_wr_en     =
    (state_q == S_WB) & dec_reg_wr & pc_ok;

endmodule

// File: tb/tb_riscv_mc_sequencer.sv
// Scoreboard bench for riscv_mc_sequencer: directed programs,
// expected events queued by stimulus, checked by a monitor.
module tb_riscv_mc_sequencer;

  localparam logic [31:0] RPC = 32'h100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_mc_sequencer_if #(.XLEN(32)) bus ();
  riscv_mc_sequencer_if #(.XLEN(32)) bus_nt ();

  logic [31:0] instruction;
  logic        dec_load;
  logic        dec_store;
  logic        dec_reg_wr;
  logic        dec_illegal;
  logic [31:0] next_pc;
  logic [31:0] pc;
  logic        reg_wr_en;
  logic [3:0]  instret;
  logic        halted;
  logic [1:0]  halt_cause;

  logic [31:0] instruction_nt;
  logic [31:0] pc_nt;
  logic        reg_wr_en_nt;
  logic [31:0] instret_nt;
  logic        halted_nt;
  logic [1:0]  halt_cause_nt;

  riscv_mc_sequencer #(
    .XLEN(32), .RESET_PC(RPC), .CNT_W(4), .TIMEOUT(4)
  ) u_dut (
    .clk(clk), .rst(rst), .mem(bus),
    .instruction(instruction),
    .dec_load(dec_load), .dec_store(dec_store),
    .dec_reg_wr(dec_reg_wr), .dec_illegal(dec_illegal),
    .next_pc(next_pc), .pc(pc), .reg_wr_en(reg_wr_en),
    .instret(instret), .halted(halted),
    .halt_cause(halt_cause)
  );

  riscv_mc_sequencer #(
    .XLEN(32), .RESET_PC(RPC), .CNT_W(32), .TIMEOUT(0)
  ) u_dut_nt (
    .clk(clk), .rst(rst), .mem(bus_nt),
    .instruction(instruction_nt),
    .dec_load(1'b0), .dec_store(1'b0),
    .dec_reg_wr(1'b0), .dec_illegal(1'b0),
    .next_pc(RPC + 32'd4), .pc(pc_nt),
    .reg_wr_en(reg_wr_en_nt), .instret(instret_nt),
    .halted(halted_nt), .halt_cause(halt_cause_nt)
  );

  assign bus_nt.imem_rvalid = 1'b0;
  assign bus_nt.imem_rdata  = 32'h0000_0013;
  assign bus_nt.dmem_rvalid = 1'b0;

  int          imem_lat = 0;
  int          dmem_lat = 0;
  logic [31:0] iword    = 32'h0000_0013;
  logic [31:0] alt_word = 32'h0000_0013;
  logic [31:0] alt_addr = 32'hffff_fff0;
  logic        force_en = 1'b0;
  logic [31:0] force_pc = 32'h0;

  assign bus.imem_rdata =
    (bus.imem_addr == alt_addr) ? alt_word : iword;

  always_comb next_pc = force_en ? force_pc : pc + 32'd4;

  logic [6:0] op;
  assign op = instruction[6:0];
  always_comb begin
    dec_load    = (op == 7'h03);
    dec_store   = (op == 7'h23);
    dec_reg_wr  = op inside {7'h03, 7'h13, 7'h33, 7'h37,
                             7'h17, 7'h6f, 7'h67};
    dec_illegal = !(dec_reg_wr || dec_store || op == 7'h63);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  typedef enum int {EV_WR, EV_MEM, EV_RET, EV_HALT} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int          p0;
    logic [31:0] p1;
    logic [31:0] p2;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  function automatic ev_t mk(ev_kind_t k, int c,
                             logic [31:0] a, logic [31:0] b);
    ev_t e;
    e.kind = k;
    e.p0   = c;
    e.p1   = a;
    e.p2   = b;
    return e;
  endfunction

  function automatic void expect_ev(ev_kind_t k, int c,
                                    logic [31:0] a,
                                    logic [31:0] b);
    exp_q.push_back(mk(k, c, a, b));
  endfunction

  function automatic void observe(ev_t g);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_%s got cyc=%0d a=%h b=%h",
               g.kind.name(), g.p0, g.p1, g.p2);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != g.kind || e.p0 != g.p0 ||
          e.p1 !== g.p1 || e.p2 !== g.p2) begin
        n_bad++;
        $display("FAIL event got %s cyc=%0d a=%h b=%h want %s cyc=%0d a=%h b=%h",
                 g.kind.name(), g.p0, g.p1, g.p2,
                 e.kind.name(), e.p0, e.p1, e.p2);
      end
    end
  endfunction

  int         icnt = 0;
  int         dcnt = 0;
  int         rc = 0;
  int         wc = 0;
  logic [3:0] prev_ret = '0;
  logic       prev_halt = 1'b0;

  // memory responders, then the monitor, on the falling edge
  always @(negedge clk) begin
    if (bus.imem_req) begin
      bus.imem_rvalid = (icnt == imem_lat);
      icnt++;
    end else begin
      bus.imem_rvalid = 1'b0;
      icnt = 0;
    end
    if (bus.dmem_req) begin
      bus.dmem_rvalid = (dcnt == dmem_lat);
      dcnt++;
      rc++;
      wc += int'(bus.dmem_we);
    end else begin
      bus.dmem_rvalid = 1'b0;
      dcnt = 0;
      rc = 0;
      wc = 0;
    end
    if (cyc != 0) begin
      if (reg_wr_en)
        observe(mk(EV_WR, cyc, pc, 32'd0));
      if (bus.dmem_req && bus.dmem_rvalid)
        observe(mk(EV_MEM, cyc, 32'(wc), 32'(rc)));
      if (instret != prev_ret)
        observe(mk(EV_RET, cyc, pc, 32'(instret)));
      if (halted && !prev_halt)
        observe(mk(EV_HALT, cyc, pc, 32'(halt_cause)));
    end
    prev_ret  = instret;
    prev_halt = halted;
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_to(input int n);
    int guard = 0;
    while (cyc < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < n) check("run_to_bound", 32'(cyc), 32'(n));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_pc", pc, RPC);
    check("rst_ir", instruction, 32'h0000_0013);
    check("rst_instret", 32'(instret), 32'd0);
    check("rst_cause", 32'(halt_cause), 32'd0);
    check("rst_strobes",
          {27'd0, bus.imem_req, bus.dmem_req, bus.dmem_we,
           reg_wr_en, halted}, 32'd0);
    rst = 1'b0;
  endtask

  task automatic cfg(input logic [31:0] iw,
                     input int il, input int dl);
    iword    = iw;
    imem_lat = il;
    dmem_lat = dl;
    alt_addr = 32'hffff_fff0;
    force_en = 1'b0;
  endtask

  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] LW   = 32'h0000_2083;
  localparam logic [31:0] SW   = 32'h0010_2023;

  initial begin
    int ireq;
    @(negedge clk);

    // ALU op, zero-wait fetch
    do_reset();
    cfg(ADDI, 0, 0);
    expect_ev(EV_WR, 3, RPC, 0);
    expect_ev(EV_RET, 4, RPC + 4, 1);
    run_to(5);
    check("alu_pc", pc, RPC + 4);

    // load, data ack on the 4th MEM cycle (timeout boundary)
    do_reset();
    cfg(LW, 0, 3);
    expect_ev(EV_MEM, 6, 0, 4);
    expect_ev(EV_WR, 7, RPC, 0);
    expect_ev(EV_RET, 8, RPC + 4, 1);
    run_to(8);

    // store, immediate ack, no register write
    do_reset();
    cfg(SW, 0, 0);
    expect_ev(EV_MEM, 3, 1, 1);
    expect_ev(EV_RET, 5, RPC + 4, 1);
    run_to(5);

    // jump to 0x40, illegal word there
    do_reset();
    cfg(ADDI, 0, 0);
    force_en = 1'b1;
    force_pc = 32'h40;
    alt_addr = 32'h40;
    alt_word = 32'hffff_ffff;
    expect_ev(EV_WR, 3, RPC, 0);
    expect_ev(EV_RET, 4, 32'h40, 1);
    expect_ev(EV_HALT, 6, 32'h40, 1);
    run_to(6);
    ireq = 0;
    repeat (10) begin
      @(negedge clk);
      ireq += int'(bus.imem_req);
    end
    check("ill_no_ireq", 32'(ireq), 0);
    check("ill_pc", pc, 32'h40);
    check("ill_halted", 32'(halted), 1);

    // fetch never acked
    do_reset();
    cfg(ADDI, -1, 0);
    expect_ev(EV_HALT, 5, RPC, 2);
    run_to(7);
    check("tmo_ireq", 32'(bus.imem_req), 0);

    // data never acked
    do_reset();
    cfg(LW, 0, -1);
    expect_ev(EV_HALT, 7, RPC, 2);
    run_to(8);
    check("dtmo_instret", 32'(instret), 0);

    // misaligned next_pc
    do_reset();
    cfg(ADDI, 0, 0);
    force_en = 1'b1;
    force_pc = 32'h102;
    expect_ev(EV_HALT, 4, RPC, 3);
    run_to(6);
    check("mis_instret", 32'(instret), 0);
    check("mis_pc", pc, RPC);

    // TIMEOUT=0 instance waits forever
    do_reset();
    cfg(ADDI, -1, 0);
    expect_ev(EV_HALT, 5, RPC, 2);
    run_to(300);
    check("nt_halted", 32'(halted_nt), 0);
    check("nt_ireq", 32'(bus_nt.imem_req), 1);
    check("nt_pc", pc_nt, RPC);

    // 16 retirements wrap a 4-bit counter
    do_reset();
    cfg(ADDI, 0, 0);
    for (int k = 0; k < 16; k++) begin
      expect_ev(EV_WR, 3 + 3 * k, RPC + 32'(4 * k), 0);
      expect_ev(EV_RET, 4 + 3 * k, RPC + 32'(4 * (k + 1)),
                32'((k + 1) % 16));
    end
    run_to(50);
    check("wrap_instret", 32'(instret), 0);

    // reset while a load is waiting in MEM
    do_reset();
    cfg(ADDI, 0, 2);
    alt_addr = RPC + 4;
    alt_word = LW;
    expect_ev(EV_WR, 3, RPC, 0);
    expect_ev(EV_RET, 4, RPC + 4, 1);
    run_to(7);
    check("mid_mem_dreq", 32'(bus.dmem_req), 1);
    do_reset();
    cfg(ADDI, 0, 0);
    expect_ev(EV_WR, 3, RPC, 0);
    expect_ev(EV_RET, 4, RPC + 4, 1);
    run_to(5);

    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_%s cyc=%0d a=%h b=%h",
               e.kind.name(), e.p0, e.p1, e.p2);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
